// File: rtl/fibonacci.sv
// Free-running Fibonacci term generator: one term per clock on f, restarting
// from 0 after the largest term that fits in WIDTH bits.
module fibonacci #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             clr,
  output logic [WIDTH-1:0] f
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             last_q, last_d;
  logic [WIDTH:0]   sum;

  // The carry out of a + b means b is about to take a value that cannot be
  // represented, so the b we are moving into a is the final in-range term.
  // last_q remembers that, and the following step restarts at 0, 1 instead
  // of emitting the truncated sum.
  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    a_d    = b_q;
    b_d    = sum[WIDTH-1:0];
    last_d = sum[WIDTH];
    if (last_q) begin
      a_d    = '0;
      b_d    = {{(WIDTH-1){1'b0}}, 1'b1};
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_q    <= '0;
      b_q    <= {{(WIDTH-1){1'b0}}, 1'b1};
      last_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      last_q <= last_d;
    end
  end

  assign f = a_q;

endmodule

// File: tb/tb_fibonacci.sv
// Scoreboard bench for fibonacci: a reference model queues the expected term
// on every rising edge, and the monitor compares f on the falling edge.
module tb_fibonacci;
  localparam int WIDTH = 14;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             clr;
  logic [WIDTH-1:0] f;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_cur, m_nxt;
  int bad_seen = 0;
  bit long_run = 0;
  int o1, o2, nv;
  int cyc = 0, last_zero = -1;

  fibonacci #(.WIDTH(WIDTH)) dut (.clk(clk), .clr(clr), .f(f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: unbounded integers, restart when the next term overflows.
  always @(negedge clr) begin
    m_cur = 0;
    m_nxt = 1;
  end

  always @(posedge clk) begin
    if (clr) begin
      if (m_nxt > MAXV) begin
        m_cur = 0;
        m_nxt = 1;
      end else begin
        int t;
        t     = m_cur + m_nxt;
        m_cur = m_nxt;
        m_nxt = t;
      end
    end else begin
      m_cur = 0;
      m_nxt = 1;
    end
    exp_q.push_back(m_cur);
  end

  always @(negedge clk) begin
    int fv;
    fv = int'(f);
    if (exp_q.size() > 0) chk("seq", fv, exp_q.pop_front());
    if (fv == 17711 || fv == 1327) bad_seen++;
    cyc++;
    if (!clr) nv = 0;
    else if (long_run) begin
      if (nv >= 2) begin
        if (o1 == 10946)  chk("sum_wrap0", fv, 0);
        else if (o1 == 0) chk("sum_wrap1", fv, 1);
        else              chk("sum", fv, o1 + o2);
      end
      if (fv == 0) begin
        if (last_zero >= 0) chk("period", cyc - last_zero, 22);
        last_zero = cyc;
      end
      o2 = o1;
      o1 = fv;
      nv++;
    end
  end

  initial begin
    bit found;
    m_cur = 0;
    m_nxt = 1;
    nv    = 0;
    o1    = 0;
    o2    = 0;
    clr   = 1'b0;

    // Hold in reset for 10 edges.
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_f", int'(f), 0);
    chk("rst_b", int'(dut.b_q), 1);

    // Release between edges and run past the wrap.
    #2 clr = 1'b1;
    repeat (30) @(posedge clk);

    // Find f == 233, then clear asynchronously mid-cycle.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (f == 233) found = 1;
    end
    chk("find233", int'(found), 1);
    #2 clr = 1'b0;
    #1 chk("async_clr", int'(f), 0);
    #1 clr = 1'b1;
    repeat (10) @(posedge clk);

    // Long run with property checks.
    @(negedge clk);
    #1;
    nv        = 0;
    last_zero = -1;
    long_run  = 1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    #1;
    long_run = 0;

    // 1 ns reset glitch between edges.
    #2 clr = 1'b0;
    #0.5 chk("glitch_clr", int'(f), 0);
    #0.5 clr = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1;

    chk("no_17711_1327", bad_seen, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fibonacci.md
# fibonacci

Free-running Fibonacci sequence generator. It emits one term of the sequence per clock on a 14-bit output, starting from 0 after reset. The sequence restarts from 0 after the largest term that fits in the output width. It is a self-contained source block with no input handshake, used as a stimulus or pattern generator.

## Interface
- WIDTH, 14, output and term-register width in bits. The bench uses only the default; all concrete values below assume WIDTH = 14.
- clk  input  1  clock. All state changes on the rising edge, except reset.
- clr  input  1  asynchronous, active-low reset. clr = 0 forces reset state immediately, independent of clk.
- f  output  WIDTH  current Fibonacci term, registered.

## Operation
- Internal state is two WIDTH-bit registers:
  - a: the current term, driven directly on f.
  - b: the next term.
- Reset (clr = 0, asynchronous): a = 0, b = 1, so f = 0 immediately. State is held for as long as clr stays low.
- Each rising clk with clr = 1:
  - Normal step: a <= b; b <= a + b.
  - Wrap step: applies when a is already the largest in-range term, i.e. a + b exceeds 2^WIDTH − 1. Detect this with a (WIDTH+1)-bit sum and its carry / overflow. Then a <= 0 and b <= 1, restarting the sequence.
- Output sequence from reset, one term per cycle: 0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987, 1597, 2584, 4181, 6765, 10946, then 0, 1, 1, …
- Period is 22 cycles (F0..F21); 10946 is the last 14-bit term.
- f never shows a truncated or wrapped-arithmetic value; 17711 never appears, not even modulo 2^14 (1327).
- Arithmetic is unsigned. For the generic WIDTH, the wrap point is the largest Fibonacci number ≤ 2^WIDTH − 1, found by the same carry rule.
- No other inputs: no enable and no load.

## Timing
- f is a register output with no combinational path from any input, except the asynchronous clear.
- Reset assertion: f = 0 within the same delta, with no clock required.
- Reset release: the first rising edge with clr = 1 gives f = 1. The second gives f = 1 and the third gives f = 2.
- Release coincident with a rising edge: this is a recovery violation. The design tolerates it by producing either f = 0 or f = 1 after that edge, and the sequence is correct from then on. Benches release clr away from clk edges.
- Reset mid-sequence: f = 0 at once. The sequence restarts from 0, 1, 1, … after release, regardless of the prior term.
- Latency: each term is valid for exactly one clock cycle. The wrap from 10946 to 0 takes one edge, with no idle or stall cycle.
- X handling: clk and clr are assumed to be known values after time 0. Before the first reset, the state is undefined; the bench must apply clr = 0 first.

## Test plan
- Hold in reset: clr = 0 for 10 clock edges -> f = 0 on every cycle; b internally 1.
- Sequence start: release clr between edges -> after edges 1..8, f = 1, 1, 2, 3, 5, 8, 13, 21.
- Full period and wrap: run 25 edges after release -> f reaches 6765, then 10946, then 0, 1, 1, 2. Check explicitly that 17711 and 1327 never appear.
- Mid-run asynchronous reset: at f = 233, pull clr low mid-cycle -> f = 0 immediately, before the next edge. Release -> f = 1, 1, 2, …
- Long run: 1000 cycles compared against a reference model.
  - Each term equals the sum of the previous two, except the forced 0/1 after 10946.
  - Period is exactly 22.
- Reset glitch: a 1 ns clr low pulse between edges -> f = 0 and the sequence restarts from the beginning.
